fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined MIPS datapath. It supersedes the fixed 2-operand, 2-stage forwarding logic.
- Keeps an internal shadow of destination info for EX and the FWD_DEPTH stages after it. Produces independent per-operand forward selects for the instruction in EX.
- Raises stall to the ID stage on load-use hazards, accepts branch flush, and counts stall cycles.

Parameters:
- ADDR_W, 5, register address width.
- NUM_SRC, 2, source operands per instruction (rs, rt, ...).
- FWD_DEPTH, 2, post-EX stages able to forward (1 = EX/MEM, 2 = MEM/WB, ...). Must be ≥ 1.
- LOAD_LAT, 1, stages after EX before load data exists. Stage k can forward a load only if k ≥ LOAD_LAT+1. Requires LOAD_LAT < FWD_DEPTH.
- CNT_W, 16, stall counter width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- id_valid, in, 1, ID holds a real instruction.
- id_src_addr, in, NUM_SRC*ADDR_W, ID source register addresses; operand i is at bits [i*ADDR_W +: ADDR_W].
- id_rd_addr, in, ADDR_W, ID destination address.
- id_reg_write, in, 1, ID instruction writes the register file.
- id_mem_read, in, 1, ID instruction is a load.
- flush, in, 1, kill the instruction in ID this cycle.
- stall, out, 1, hold PC and IF/ID; combinational.
- ex_valid, out, 1, stage 0 (EX) holds a real instruction.
- ex_fwd_sel, out, NUM_SRC*SEL_W, per-operand select. SEL_W = clog2(FWD_DEPTH+1). Value 0 = register file; value k = stage k result.
- stall_cnt, out, CNT_W, saturating count of stall cycles.

Behaviour:
Stage entries and shifting:
- Entry fields: valid, reg_write, mem_read, rd, src[NUM_SRC].
- Stage 0 = EX. Stages 1..FWD_DEPTH follow it.
- Every clock: stage k+1 ← stage k for k = 0..FWD_DEPTH-1, unconditionally. Later stages never stall.
- Stage 0 ← ID fields when id_valid & !stall & !flush. Otherwise stage 0 ← bubble (valid=0, other fields 0).

Producer and hazard rules:
- Producer match for address a at stage j: valid & reg_write & rd≠0 & rd==a.
- stall = id_valid & !flush & (some operand i has a producer match at some stage j < LOAD_LAT with mem_read=1).
- A match on address 0 never stalls and never forwards.

Forward select (operand i, from stage 0 src[i]):
- sel = the smallest k in 1..FWD_DEPTH with a producer match, i.e. the youngest producer wins.
- Operands are evaluated independently; several operands may forward in the same cycle.
- No match gives 0.
- If stage 0 is invalid, all sels are 0.
- Combinational from registered state only; no dependence on ID inputs.

Timing and boundary cases:
- ALU producer at stage 0 while the consumer is in ID: no stall. Next cycle sel=1.
- Load at stage j < LOAD_LAT: stall for LOAD_LAT-j cycles. Bubbles enter stage 0 until the load reaches stage LOAD_LAT, then the consumer issues with sel=LOAD_LAT+1.
- Producer beyond FWD_DEPTH: the register file supplies the value (write-before-read); sel=0.
- Flush and stall in the same cycle: flush wins. stall=0, a bubble is inserted, and the counter does not increment.

Stall counter:
- Increments by 1 on each cycle with stall=1.
- Saturates at 2^CNT_W-1.

Reset:
- rst=1 at a clock edge clears all stages (invalid, fields 0) and stall_cnt.
- After reset: stall=0, ex_valid=0, ex_fwd_sel=0.
- Reset mid-stall abandons the hazard. Stages are empty afterwards, so no stall follows.

Decomposition:
- Shared package fwd_pkg holds:
  - the stage entry struct type;
  - the SEL_W helper function (clog2);
  - constant SEL_REGFILE = 0.
- One sub-module, fwd_match_prio. It takes one address plus the stage vector and returns SEL_W sel and a load_block flag. It is instantiated NUM_SRC times for forwarding and NUM_SRC times for ID-side hazard checking.

Test Plan:
1. Back-to-back ALU dependence (defaults):
   - Stimulus: issue add rd=3; next cycle issue sub src0=3, src1=3.
   - Required: next cycle ex_fwd_sel = {1,1}, stall never 1.
2. Distance-2 ALU producer overridden by a younger one:
   - Stimulus: rd=5, then rd=5, then consumer src0=5.
   - Required: sel0=1, never 2.
   - Variant: rd=5, nop, consumer src0=5 gives sel0=2.
3. Load-use (LOAD_LAT=1):
   - Stimulus: lw rd=7, then consumer src1=7.
   - Required: stall=1 for exactly 1 cycle, ex_valid=0 that cycle, then sel1=2 and stall_cnt=1.
4. Register 0 and independent operands:
   - Stimulus: producer rd=0 reg_write=1, then consumer src0=0 → sel0=0, no stall.
   - Stimulus: producer rd=4, consumer src0=9, src1=4 → sel={0,1}.
5. Flush during load-use:
   - Stimulus: lw rd=2, then consumer src0=2 with flush=1.
   - Required: stall=0, bubble in EX, stall_cnt unchanged.
   - Reset check: rst asserted during a 2-cycle stall (LOAD_LAT=2 build) clears stall next cycle and stall_cnt=0.
6. Parameter sweep FWD_DEPTH=3, LOAD_LAT=2, NUM_SRC=3:
   - Stimulus: lw rd=6, then consumer with all three srcs=6.
   - Required: 2 stall cycles, then all sels=3.
   - Counter width: CNT_W=2 build stalls 5 times and stall_cnt saturates at 3.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
// A stage entry carries the destination-side information of one pipeline slot.
package fwd_pkg;

    localparam int ADDR_W_MAX  = 8;
    localparam int SEL_REGFILE = 0;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic [ADDR_W_MAX-1:0] rd;
    } stage_t;

    function automatic int sel_w(input int fwd_depth);
        return (fwd_depth < 1) ? 1 : $clog2(fwd_depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match_prio.sv
// Matches one source address against the stage shadow: youngest post-EX producer
// select, plus a flag for a load producer whose data is not yet available.
module fwd_match_prio
    import fwd_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    localparam int SEL_W    = sel_w(FWD_DEPTH)
) (
    input  logic [ADDR_W-1:0] addr,
    input  stage_t            stages [0:FWD_DEPTH],
    output logic [SEL_W-1:0]  sel,
    output logic              load_block
);

    logic [FWD_DEPTH:0] hit;

    always_comb begin
        hit = '0;
        for (int j = 0; j <= FWD_DEPTH; j++) begin
            hit[j] = stages[j].valid && stages[j].reg_write &&
                     (stages[j].rd != '0) && (stages[j].rd == ADDR_W_MAX'(addr));
        end
    end

    always_comb begin
        sel        = SEL_W'(SEL_REGFILE);
        load_block = 1'b0;
        // Walk oldest to youngest so the youngest producer's index is left in sel.
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (hit[k]) sel = SEL_W'(k);
        end
        for (int j = 0; j <= FWD_DEPTH; j++) begin
            if (hit[j] && stages[j].mem_read && (j < LOAD_LAT)) load_block = 1'b1;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Parametrised forwarding select and load-use stall generation for the EX stage,
// with a saturating count of stall cycles.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int CNT_W     = 16,
    localparam int SEL_W    = sel_w(FWD_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
    input  logic [ADDR_W-1:0]         id_rd_addr,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      flush,
    output logic                      stall,
    output logic                      ex_valid,
    output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt
);

    stage_t                    stages [0:FWD_DEPTH];
    // Source addresses only matter while the instruction sits in EX.
    logic [ADDR_W-1:0]         ex_src [NUM_SRC];
    logic [NUM_SRC-1:0]        id_block;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_raw;
    logic [NUM_SRC-1:0]        unused_fwd_block;
    logic [SEL_W-1:0]          unused_id_sel [NUM_SRC];
    logic                      issue;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match_prio #(.ADDR_W(ADDR_W), .FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT)) u_fwd (
            .addr       (ex_src[i]),
            .stages     (stages),
            .sel        (fwd_sel_raw[i*SEL_W +: SEL_W]),
            .load_block (unused_fwd_block[i])
        );

        fwd_match_prio #(.ADDR_W(ADDR_W), .FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT)) u_id (
            .addr       (id_src_addr[i*ADDR_W +: ADDR_W]),
            .stages     (stages),
            .sel        (unused_id_sel[i]),
            .load_block (id_block[i])
        );
    end

    assign stall      = id_valid && !flush && (|id_block);
    assign issue      = id_valid && !stall && !flush;
    assign ex_valid   = stages[0].valid;
    assign ex_fwd_sel = stages[0].valid ? fwd_sel_raw : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= FWD_DEPTH; k++) stages[k] <= '0;
            for (int i = 0; i < NUM_SRC; i++) ex_src[i] <= '0;
            stall_cnt <= '0;
        end else begin
            for (int k = FWD_DEPTH; k >= 1; k--) stages[k] <= stages[k-1];
            if (issue) begin
                stages[0].valid     <= 1'b1;
                stages[0].reg_write <= id_reg_write;
                stages[0].mem_read  <= id_mem_read;
                stages[0].rd        <= ADDR_W_MAX'(id_rd_addr);
                for (int i = 0; i < NUM_SRC; i++) ex_src[i] <= id_src_addr[i*ADDR_W +: ADDR_W];
            end else begin
                stages[0] <= '0;
                for (int i = 0; i < NUM_SRC; i++) ex_src[i] <= '0;
            end
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: default build against a pipeline-history model,
// plus directed checks on a deep build (3 srcs, depth 3, load latency 2) and a 2-bit counter build.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // default build
    logic       a_rst, a_idv, a_rw, a_mr, a_fl, a_stall, a_exv;
    logic [9:0] a_src;
    logic [4:0] a_rd;
    logic [3:0] a_sel;
    logic [15:0] a_cnt;
    // NUM_SRC=3, FWD_DEPTH=3, LOAD_LAT=2
    logic        b_rst, b_idv, b_rw, b_mr, b_fl, b_stall, b_exv;
    logic [14:0] b_src;
    logic [4:0]  b_rd;
    logic [5:0]  b_sel;
    logic [15:0] b_cnt;
    // CNT_W=2
    logic       c_rst, c_idv, c_rw, c_mr, c_fl, c_stall, c_exv;
    logic [9:0] c_src;
    logic [4:0] c_rd;
    logic [3:0] c_sel;
    logic [1:0] c_cnt;

    fwd_hazard_unit u_a (
        .clk(clk), .rst(a_rst), .id_valid(a_idv), .id_src_addr(a_src), .id_rd_addr(a_rd),
        .id_reg_write(a_rw), .id_mem_read(a_mr), .flush(a_fl), .stall(a_stall),
        .ex_valid(a_exv), .ex_fwd_sel(a_sel), .stall_cnt(a_cnt)
    );

    fwd_hazard_unit #(.NUM_SRC(3), .FWD_DEPTH(3), .LOAD_LAT(2)) u_b (
        .clk(clk), .rst(b_rst), .id_valid(b_idv), .id_src_addr(b_src), .id_rd_addr(b_rd),
        .id_reg_write(b_rw), .id_mem_read(b_mr), .flush(b_fl), .stall(b_stall),
        .ex_valid(b_exv), .ex_fwd_sel(b_sel), .stall_cnt(b_cnt)
    );

    fwd_hazard_unit #(.CNT_W(2)) u_c (
        .clk(clk), .rst(c_rst), .id_valid(c_idv), .id_src_addr(c_src), .id_rd_addr(c_rd),
        .id_reg_write(c_rw), .id_mem_read(c_mr), .flush(c_fl), .stall(c_stall),
        .ex_valid(c_exv), .ex_fwd_sel(c_sel), .stall_cnt(c_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: history of what occupied EX d cycles ago (d = 0 is now).
    logic       hv [0:2];
    logic       hrw[0:2];
    logic       hmr[0:2];
    logic [4:0] hrd[0:2];
    logic [4:0] hs0[0:2];
    logic [4:0] hs1[0:2];
    int         mcnt;

    function automatic logic writes(input int d, input logic [4:0] a);
        return hv[d] && hrw[d] && (hrd[d] != 5'd0) && (hrd[d] == a);
    endfunction

    function automatic int m_fwd(input logic [4:0] a);
        if (!hv[0]) return 0;
        for (int d = 1; d <= 2; d++) if (writes(d, a)) return d;
        return 0;
    endfunction

    // With load latency 1, only a load currently in EX has no data yet.
    function automatic logic m_hazard(input logic [4:0] a);
        return writes(0, a) && hmr[0];
    endfunction

    task automatic m_reset();
        for (int d = 0; d <= 2; d++) begin
            hv[d] = 0; hrw[d] = 0; hmr[d] = 0; hrd[d] = 0; hs0[d] = 0; hs1[d] = 0;
        end
        mcnt = 0;
    endtask

    task automatic step_a(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [4:0] rd, input logic rw, input logic mr,
                          input logic fl, output logic st);
        logic m_st;
        int   e0, e1;
        a_idv = v; a_src = {s1, s0}; a_rd = rd; a_rw = rw; a_mr = mr; a_fl = fl;
        #2;
        m_st = v && !fl && (m_hazard(s0) || m_hazard(s1));
        e0 = m_fwd(hs0[0]);
        e1 = m_fwd(hs1[0]);
        chk("a_stall", 32'(a_stall), 32'(m_st));
        chk("a_ex_valid", 32'(a_exv), 32'(hv[0]));
        chk("a_sel0", 32'(a_sel[1:0]), 32'(e0));
        chk("a_sel1", 32'(a_sel[3:2]), 32'(e1));
        chk("a_cnt", 32'(a_cnt), 32'(mcnt));
        st = a_stall;
        @(posedge clk); #1;
        for (int d = 2; d >= 1; d--) begin
            hv[d] = hv[d-1]; hrw[d] = hrw[d-1]; hmr[d] = hmr[d-1];
            hrd[d] = hrd[d-1]; hs0[d] = hs0[d-1]; hs1[d] = hs1[d-1];
        end
        if (v && !m_st && !fl) begin
            hv[0] = 1; hrw[0] = rw; hmr[0] = mr; hrd[0] = rd; hs0[0] = s0; hs1[0] = s1;
        end else begin
            hv[0] = 0; hrw[0] = 0; hmr[0] = 0; hrd[0] = 0; hs0[0] = 0; hs1[0] = 0;
        end
        if (m_st && mcnt < 65535) mcnt++;
    endtask

    task automatic reset_a();
        a_rst = 1; a_idv = 0; a_fl = 0;
        @(posedge clk); #1;
        a_rst = 0;
        m_reset();
    endtask

    task automatic step_b(input logic v, input logic [4:0] s, input logic [4:0] rd,
                          input logic rw, input logic mr, output logic st);
        b_idv = v; b_src = {s, s, s}; b_rd = rd; b_rw = rw; b_mr = mr; b_fl = 0;
        #2;
        st = b_stall;
        @(posedge clk); #1;
    endtask

    task automatic step_c(input logic v, input logic [4:0] s, input logic [4:0] rd,
                          input logic rw, input logic mr, output logic st);
        c_idv = v; c_src = {5'd0, s}; c_rd = rd; c_rw = rw; c_mr = mr; c_fl = 0;
        #2;
        st = c_stall;
        @(posedge clk); #1;
    endtask

    initial begin
        logic       st;
        logic       r_v, r_rw, r_mr, r_fl;
        logic [4:0] r_s0, r_s1, r_rd;

        a_rst = 1; a_idv = 0; a_src = 0; a_rd = 0; a_rw = 0; a_mr = 0; a_fl = 0;
        b_rst = 1; b_idv = 0; b_src = 0; b_rd = 0; b_rw = 0; b_mr = 0; b_fl = 0;
        c_rst = 1; c_idv = 0; c_src = 0; c_rd = 0; c_rw = 0; c_mr = 0; c_fl = 0;
        m_reset();
        @(posedge clk); #1;
        chk("rst_a_ex_valid", 32'(a_exv), 32'h0);
        chk("rst_a_sel", 32'(a_sel), 32'h0);
        chk("rst_a_cnt", 32'(a_cnt), 32'h0);
        chk("rst_b_sel", 32'(b_sel), 32'h0);
        chk("rst_c_cnt", 32'(c_cnt), 32'h0);
        a_rst = 0; b_rst = 0; c_rst = 0;

        // back-to-back ALU dependence
        step_a(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, st);
        step_a(1, 5'd3, 5'd3, 5'd8, 1, 0, 0, st);
        chk("t1_stall", 32'(st), 32'h0);
        chk("t1_sel", 32'(a_sel), 32'h5);

        // younger producer wins; distance 2 forwards from stage 2
        step_a(1, 5'd0, 5'd0, 5'd5, 1, 0, 0, st);
        step_a(1, 5'd0, 5'd0, 5'd5, 1, 0, 0, st);
        step_a(1, 5'd5, 5'd0, 5'd9, 1, 0, 0, st);
        chk("t2_sel0_young", 32'(a_sel[1:0]), 32'h1);
        step_a(1, 5'd0, 5'd0, 5'd5, 1, 0, 0, st);
        step_a(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, st);
        step_a(1, 5'd5, 5'd0, 5'd9, 1, 0, 0, st);
        chk("t2_sel0_dist2", 32'(a_sel[1:0]), 32'h2);

        // load-use: one stall cycle, then forward from stage 2
        reset_a();
        step_a(1, 5'd0, 5'd0, 5'd7, 1, 1, 0, st);
        step_a(1, 5'd0, 5'd7, 5'd10, 1, 0, 0, st);
        chk("t3_stall_first", 32'(st), 32'h1);
        chk("t3_bubble", 32'(a_exv), 32'h0);
        step_a(1, 5'd0, 5'd7, 5'd10, 1, 0, 0, st);
        chk("t3_stall_second", 32'(st), 32'h0);
        chk("t3_sel1", 32'(a_sel[3:2]), 32'h2);
        chk("t3_cnt", 32'(a_cnt), 32'h1);

        // register 0 never forwards; operands independent
        step_a(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, st);
        step_a(1, 5'd0, 5'd0, 5'd11, 1, 0, 0, st);
        chk("t4_r0_stall", 32'(st), 32'h0);
        chk("t4_r0_sel", 32'(a_sel), 32'h0);
        step_a(1, 5'd0, 5'd0, 5'd4, 1, 0, 0, st);
        step_a(1, 5'd9, 5'd4, 5'd12, 1, 0, 0, st);
        chk("t4_indep_sel", 32'(a_sel), 32'h4);

        // flush beats stall
        step_a(1, 5'd0, 5'd0, 5'd2, 1, 1, 0, st);
        step_a(1, 5'd2, 5'd0, 5'd13, 1, 0, 1, st);
        chk("t5_flush_stall", 32'(st), 32'h0);
        chk("t5_flush_bubble", 32'(a_exv), 32'h0);
        chk("t5_flush_cnt", 32'(a_cnt), 32'h1);

        // randomized traffic against the model; a stalled instruction is held in ID
        st = 0;
        r_v = 0; r_rw = 0; r_mr = 0; r_s0 = 0; r_s1 = 0; r_rd = 0;
        for (int n = 0; n < 400; n++) begin
            if (!st) begin
                r_v  = ($urandom_range(0, 9) < 8);
                r_s0 = 5'($urandom_range(0, 7));
                r_s1 = 5'($urandom_range(0, 7));
                r_rd = 5'($urandom_range(0, 7));
                r_rw = ($urandom_range(0, 4) != 0);
                r_mr = ($urandom_range(0, 2) == 0);
            end
            r_fl = ($urandom_range(0, 11) == 0);
            step_a(r_v, r_s0, r_s1, r_rd, r_rw, r_mr, r_fl, st);
        end

        // deep build: two stall cycles, then all three operands from stage 3
        step_b(1, 5'd0, 5'd6, 1, 1, st);
        chk("t6_lw_stall", 32'(st), 32'h0);
        step_b(1, 5'd6, 5'd14, 1, 0, st);
        chk("t6_stall_1", 32'(st), 32'h1);
        chk("t6_bubble", 32'(b_exv), 32'h0);
        step_b(1, 5'd6, 5'd14, 1, 0, st);
        chk("t6_stall_2", 32'(st), 32'h1);
        step_b(1, 5'd6, 5'd14, 1, 0, st);
        chk("t6_stall_3", 32'(st), 32'h0);
        chk("t6_sel", 32'(b_sel), 32'h3f);
        chk("t6_cnt", 32'(b_cnt), 32'h2);

        // reset in the middle of a two-cycle stall
        step_b(1, 5'd0, 5'd6, 1, 1, st);
        step_b(1, 5'd6, 5'd14, 1, 0, st);
        chk("t5r_stall_pre", 32'(st), 32'h1);
        b_rst = 1;
        step_b(1, 5'd6, 5'd14, 1, 0, st);
        b_rst = 0;
        chk("t5r_cnt", 32'(b_cnt), 32'h0);
        chk("t5r_ex_valid", 32'(b_exv), 32'h0);
        step_b(1, 5'd6, 5'd14, 1, 0, st);
        chk("t5r_stall_post", 32'(st), 32'h0);

        // 2-bit counter saturates at 3
        for (int r = 1; r <= 5; r++) begin
            step_c(1, 5'd0, 5'd1, 1, 1, st);
            step_c(1, 5'd1, 5'd2, 1, 0, st);
            chk("t6c_stall", 32'(st), 32'h1);
            step_c(1, 5'd1, 5'd2, 1, 0, st);
            chk("t6c_cnt", 32'(c_cnt), 32'((r < 3) ? r : 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
